sgm_path_aggregator_pipe: RTL

// - Streaming, clocked successor to the combinational SGM 1D path-aggregation stage.
// - Accepts one pixel's matching-cost vector C(p,0..MAX_DISP-1) per beat (valid/ready).
// - Keeps the previous pixel's aggregated cost L_r(p-r,*) and its minimum internally.
// - Emits L_r(p,*), min_k L_r(p,k) and the argmin disparity; sits between cost computation and the multi-path summer.

---
 rtl/sgm_path_aggregator_pipe.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sgm_path_aggregator_pipe.sv
// Streaming SGM 1D path-aggregation stage.
// S1 evaluates the path recurrence for one pixel per beat and keeps the
// previous pixel's aggregated vector and minimum as recurrence state.
// S2 registers the result and resolves the lowest-index argmin.
module sgm_path_aggregator_pipe #(
  parameter int MAX_DISP = 16,
  parameter int IN_W     = 8,
  parameter int COST_W   = 16,
  parameter int P_W      = 8,
  localparam int DISP_W  = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [P_W-1:0]             cfg_p1,
  input  logic [P_W-1:0]             cfg_p2,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_sol,
  input  logic                       s_eol,
  input  logic [MAX_DISP*IN_W-1:0]   s_cost,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [MAX_DISP*COST_W-1:0] m_cost,
  output logic [COST_W-1:0]          m_min,
  output logic [DISP_W-1:0]          m_disp,
  output logic                       m_sol,
  output logic                       m_eol
);

  localparam int CW1    = COST_W + 1;
  localparam int MAX_IP = (IN_W > P_W) ? IN_W : P_W;
  localparam logic [CW1-1:0] SAT_LIM = {1'b0, {COST_W{1'b1}}};

  // An aggregated cost never exceeds C + P2e, so this width keeps the
  // saturation path unreachable while leaving headroom for the +P1 terms.
  generate
    if (MAX_DISP < 2 || COST_W < MAX_IP + 1) begin : g_bad_params
      $error("sgm_path_aggregator_pipe: MAX_DISP must be >= 2 and COST_W wide enough for C+P2");
    end
  endgenerate

  function automatic logic [CW1-1:0] min2(input logic [CW1-1:0] a, input logic [CW1-1:0] b);
    return (b < a) ? b : a;
  endfunction

  logic                       s1_valid_q, s1_valid_d;
  logic [MAX_DISP*COST_W-1:0] s1_l_q, s1_l_d;
  logic [COST_W-1:0]          s1_min_q, s1_min_d;
  logic                       s1_sol_q, s1_sol_d;
  logic                       s1_eol_q, s1_eol_d;
  logic                       path_active_q, path_active_d;

  logic                       m_valid_q, m_valid_d;
  logic [MAX_DISP*COST_W-1:0] m_cost_q, m_cost_d;
  logic [COST_W-1:0]          m_min_q, m_min_d;
  logic [DISP_W-1:0]          m_disp_q, m_disp_d;
  logic                       m_sol_q, m_sol_d;
  logic                       m_eol_q, m_eol_d;

  logic                       en_s, accept_s, start_s;
  logic [P_W-1:0]             p2e_s;
  logic [COST_W-1:0]          lp_s [MAX_DISP];
  logic [CW1-1:0]             t_s [MAX_DISP];
  logic [CW1-1:0]             sum_s [MAX_DISP];
  logic [MAX_DISP*COST_W-1:0] l_new_s;
  logic [COST_W-1:0]          min_new_s;
  logic [DISP_W-1:0]          disp_s;

  // Unpack the S1 vector: it is both the previous pixel's L and the S2 input.
  always_comb begin
    for (int d = 0; d < MAX_DISP; d++) begin
      lp_s[d] = s1_l_q[d*COST_W +: COST_W];
    end
  end

  // Handshake and recurrence for the beat currently offered on s_*.
  always_comb begin
    en_s      = !m_valid_q || m_ready;
    accept_s  = s_valid && en_s;
    start_s   = s_sol || !path_active_q;
    p2e_s     = (cfg_p2 > cfg_p1) ? cfg_p2 : cfg_p1;
    l_new_s   = '0;
    min_new_s = '1;
    for (int d = 0; d < MAX_DISP; d++) begin
      // Edge neighbours fall back to the centre term, which is never smaller.
      t_s[d] = {1'b0, lp_s[d]};
      t_s[d] = min2(t_s[d], {1'b0, lp_s[(d > 0) ? d - 1 : d]} + CW1'(cfg_p1));
      t_s[d] = min2(t_s[d], {1'b0, lp_s[(d < MAX_DISP - 1) ? d + 1 : d]} + CW1'(cfg_p1));
      t_s[d] = min2(t_s[d], {1'b0, s1_min_q} + CW1'(p2e_s));
      sum_s[d] = CW1'(s_cost[d*IN_W +: IN_W]) + t_s[d] - {1'b0, s1_min_q};
      if (start_s) begin
        l_new_s[d*COST_W +: COST_W] = COST_W'(s_cost[d*IN_W +: IN_W]);
      end else if (sum_s[d] > SAT_LIM) begin
        l_new_s[d*COST_W +: COST_W] = SAT_LIM[COST_W-1:0];
      end else begin
        l_new_s[d*COST_W +: COST_W] = sum_s[d][COST_W-1:0];
      end
      min_new_s = (l_new_s[d*COST_W +: COST_W] < min_new_s) ? l_new_s[d*COST_W +: COST_W] : min_new_s;
    end
  end

  // S1 next state: recurrence state moves only on an accepted beat.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_l_d        = s1_l_q;
    s1_min_d      = s1_min_q;
    s1_sol_d      = s1_sol_q;
    s1_eol_d      = s1_eol_q;
    path_active_d = path_active_q;
    if (en_s) begin
      s1_valid_d = accept_s;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept_s) begin
      s1_l_d        = l_new_s;
      s1_min_d      = min_new_s;
      s1_sol_d      = s_sol;
      s1_eol_d      = s_eol;
      path_active_d = !s_eol;
    end else begin
      path_active_d = path_active_q;
    end
  end

  // Lowest disparity index whose aggregated cost equals the S1 minimum.
  always_comb begin
    disp_s = '0;
    for (int d = MAX_DISP - 1; d >= 0; d--) begin
      disp_s = (lp_s[d] == s1_min_q) ? DISP_W'(d) : disp_s;
    end
  end

  // S2 next state: load from S1 whenever the output slot is free.
  always_comb begin
    m_valid_d = m_valid_q;
    m_cost_d  = m_cost_q;
    m_min_d   = m_min_q;
    m_disp_d  = m_disp_q;
    m_sol_d   = m_sol_q;
    m_eol_d   = m_eol_q;
    if (en_s && s1_valid_q) begin
      m_valid_d = 1'b1;
      m_cost_d  = s1_l_q;
      m_min_d   = s1_min_q;
      m_disp_d  = disp_s;
      m_sol_d   = s1_sol_q;
      m_eol_d   = s1_eol_q;
    end else if (en_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Pipeline and recurrence-state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_l_q        <= '0;
      s1_min_q      <= '0;
      s1_sol_q      <= 1'b0;
      s1_eol_q      <= 1'b0;
      path_active_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_cost_q      <= '0;
      m_min_q       <= '0;
      m_disp_q      <= '0;
      m_sol_q       <= 1'b0;
      m_eol_q       <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_l_q        <= s1_l_d;
      s1_min_q      <= s1_min_d;
      s1_sol_q      <= s1_sol_d;
      s1_eol_q      <= s1_eol_d;
      path_active_q <= path_active_d;
      m_valid_q     <= m_valid_d;
      m_cost_q      <= m_cost_d;
      m_min_q       <= m_min_d;
      m_disp_q      <= m_disp_d;
      m_sol_q       <= m_sol_d;
      m_eol_q       <= m_eol_d;
    end
  end

  assign s_ready = en_s;
  assign m_valid = m_valid_q;
  assign m_cost  = m_cost_q;
  assign m_min   = m_min_q;
  assign m_disp  = m_disp_q;
  assign m_sol   = m_sol_q;
  assign m_eol   = m_eol_q;

endmodule
